// File: rtl/i4004_timing_if.sv
// i4004_timing_if -- pin-level bundle for the 4004 timing generator.
//   PHI1_i, PHI2_i, RESET_i : CPU clock phases and CPU reset pin (async to clk_i)
//   SYNC_o                  : machine-cycle sync, low in the sync state
//   state_o, state_oh_o     : current machine state, binary and one-hot
//   phi1_rise_o/phi2_rise_o : one-clk synchronized rising-edge pulses
//   cycle_end_o             : one-clk pulse on the X3 -> A1 wrap
//   cpu_clear_o             : CPU internal-clear request
//   phase_err_o             : sticky phase-error flag
// modport slave is the timing block; modport master is whoever drives the pins.
interface i4004_timing_if;
  logic       PHI1_i;
  logic       PHI2_i;
  logic       RESET_i;
  logic       SYNC_o;
  logic [2:0] state_o;
  logic [7:0] state_oh_o;
  logic       phi1_rise_o;
  logic       phi2_rise_o;
  logic       cycle_end_o;
  logic       cpu_clear_o;
  logic       phase_err_o;

  modport master (
    output PHI1_i, PHI2_i, RESET_i,
    input  SYNC_o, state_o, state_oh_o, phi1_rise_o, phi2_rise_o,
           cycle_end_o, cpu_clear_o, phase_err_o
  );

  modport slave (
    input  PHI1_i, PHI2_i, RESET_i,
    output SYNC_o, state_o, state_oh_o, phi1_rise_o, phi2_rise_o,
           cycle_end_o, cpu_clear_o, phase_err_o
  );
endinterface

// File: rtl/i4004_timing.sv
// i4004_timing -- machine-cycle timing generator for a 4004-style CPU.
// Synchronizes the two CPU clock phases and the CPU reset pin into clk_i,
// steps an 8-state machine cycle (A1..X3) on every PHI2 rising edge, and
// raises a CPU clear once RESET has been held for RESET_CYCLES machine cycles.
// Ports:
//   clk_i : design clock, all logic on its rising edge
//   rst_i : synchronous active-high block reset
//   bus   : i4004_timing_if.slave (CPU pins and status outputs)
// Parameters: SYNC_STAGES (1..4), RESET_CYCLES (1..255), SYNC_STATE (0..7).
// Optional feature: define I4004_TIMING_PHASE_CHECK_EN to build the sticky
// phase checker; otherwise phase_err_o is tied low.
module i4004_timing #(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 8,
  parameter int SYNC_STATE   = 7
) (
  input logic           clk_i,
  input logic           rst_i,
  i4004_timing_if.slave bus
);

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} state_t;

  localparam logic [2:0] SYNC_ST   = SYNC_STATE[2:0];
  localparam logic [7:0] CLEAR_CNT = RESET_CYCLES[7:0];

  function automatic logic [SYNC_STAGES-1:0] shift_in(
    input logic [SYNC_STAGES-1:0] chain,
    input logic                   d
  );
    logic [SYNC_STAGES-1:0] r;
    r    = chain << 1;
    r[0] = d;
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] phi1_sync, phi2_sync, reset_sync;
  logic                   phi1_prev, phi2_prev;
  logic                   phi1_s, phi2_s, reset_s;
  logic                   phi1_edge, phi2_edge, wrap_edge;
  state_t                 state_q, state_n;
  logic                   sync_q;
  logic [7:0]             state_oh_q;
  logic                   phi1_rise_q, phi2_rise_q, cycle_end_q, cpu_clear_q;
  logic [7:0]             reset_cnt;

  assign phi1_s    = phi1_sync[SYNC_STAGES-1];
  assign phi2_s    = phi2_sync[SYNC_STAGES-1];
  assign reset_s   = reset_sync[SYNC_STAGES-1];
  assign phi1_edge = phi1_s & ~phi1_prev;
  assign phi2_edge = phi2_s & ~phi2_prev;
  assign wrap_edge = phi2_edge && (state_q == X3);
  assign state_n   = phi2_edge ? state_t'(state_q + 3'd1) : state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // PHI chains park high so a phase already high at release is not an edge.
      phi1_sync   <= '1;
      phi2_sync   <= '1;
      phi1_prev   <= 1'b1;
      phi2_prev   <= 1'b1;
      reset_sync  <= '0;
      state_q     <= X3;
      sync_q      <= (X3 != SYNC_ST);
      state_oh_q  <= 8'h80;
      phi1_rise_q <= 1'b0;
      phi2_rise_q <= 1'b0;
      cycle_end_q <= 1'b0;
      cpu_clear_q <= 1'b0;
      reset_cnt   <= 8'd0;
    end else begin
      // Synchronizer stage: each async pin through SYNC_STAGES flops.
      phi1_sync  <= shift_in(phi1_sync, bus.PHI1_i);
      phi2_sync  <= shift_in(phi2_sync, bus.PHI2_i);
      reset_sync <= shift_in(reset_sync, bus.RESET_i);
      phi1_prev  <= phi1_s;
      phi2_prev  <= phi2_s;

      // Edge/state stage: pulses and the state-derived outputs share one edge.
      phi1_rise_q <= phi1_edge;
      phi2_rise_q <= phi2_edge;
      state_q     <= state_n;
      sync_q      <= (state_n != SYNC_ST);
      state_oh_q  <= 8'd1 << state_n;
      cycle_end_q <= wrap_edge;

      // Reset-hold counter saturates at CLEAR_CNT; clear holds with it.
      if (!reset_s) begin
        reset_cnt   <= 8'd0;
        cpu_clear_q <= 1'b0;
      end else if (wrap_edge && (reset_cnt != CLEAR_CNT)) begin
        reset_cnt   <= reset_cnt + 8'd1;
        cpu_clear_q <= ((reset_cnt + 8'd1) == CLEAR_CNT);
      end
    end
  end

`ifdef I4004_TIMING_PHASE_CHECK_EN
  logic phase_err_q;
  logic phi2_unpaired;

  // phi2_unpaired starts clear, so the first PHI2 after reset is exempt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_err_q   <= 1'b0;
      phi2_unpaired <= 1'b0;
    end else begin
      if ((phi1_s && phi2_s) || (phi2_edge && phi2_unpaired))
        phase_err_q <= 1'b1;
      if (phi1_edge)
        phi2_unpaired <= 1'b0;
      else if (phi2_edge)
        phi2_unpaired <= 1'b1;
    end
  end

  assign bus.phase_err_o = phase_err_q;
`else
  assign bus.phase_err_o = 1'b0;
`endif

  assign bus.SYNC_o      = sync_q;
  assign bus.state_o     = state_q;
  assign bus.state_oh_o  = state_oh_q;
  assign bus.phi1_rise_o = phi1_rise_q;
  assign bus.phi2_rise_o = phi2_rise_q;
  assign bus.cycle_end_o = cycle_end_q;
  assign bus.cpu_clear_o = cpu_clear_q;

endmodule

// File: tb/tb_i4004_timing.sv
// tb_i4004_timing -- directed bench for i4004_timing with a state scoreboard.
// Every PHI2 rise the bench drives pushes the expected next state; each
// phi2_rise_o pops it, and every clk the state, SYNC, one-hot, cycle_end and
// cpu_clear outputs are compared against the bench's own model.
module tb_i4004_timing;
  localparam int SS  = 2;
  localparam int RC  = 8;
  localparam int SST = 7;
`ifdef I4004_TIMING_PHASE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i4004_timing_if bus ();

  i4004_timing #(.SYNC_STAGES(SS), .RESET_CYCLES(RC), .SYNC_STATE(SST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] cur_exp = 3'd7;
  logic [2:0] pushed = 3'd7;
  int         ce_cnt = 0;
  bit         reset_active = 1'b0;
  logic       exp_clear = 1'b0;
  int         phi1_exp = 0;
  int         phi1_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rise();
    pushed = pushed + 3'd1;
    exp_q.push_back(pushed);
  endtask

  task automatic step();
    logic popped;
    popped = 1'b0;
    @(posedge clk);
    #1;
    if (bus.phi1_rise_o === 1'b1) phi1_seen++;
    if (bus.phi2_rise_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("phi2_rise_unexpected", {31'd0, bus.phi2_rise_o}, 32'd0);
      end else begin
        cur_exp = exp_q.pop_front();
        popped  = 1'b1;
        if (reset_active && cur_exp == 3'd0) begin
          ce_cnt++;
          exp_clear = (ce_cnt >= RC);
        end
      end
    end
    chk("state", {29'd0, bus.state_o}, {29'd0, cur_exp});
    chk("sync", {31'd0, bus.SYNC_o}, {31'd0, (cur_exp != SST[2:0])});
    chk("onehot", {24'd0, bus.state_oh_o}, 32'd1 << cur_exp);
    chk("cycle_end", {31'd0, bus.cycle_end_o}, {31'd0, (popped && cur_exp == 3'd0)});
    chk("cpu_clear", {31'd0, bus.cpu_clear_o}, {31'd0, exp_clear});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic phi_cycle();
    bus.PHI1_i = 1'b1;
    phi1_exp++;
    steps(3);
    bus.PHI1_i = 1'b0;
    steps(2);
    bus.PHI2_i = 1'b1;
    push_rise();
    steps(4);
    bus.PHI2_i = 1'b0;
    steps(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cur_exp      = 3'd7;
    pushed       = 3'd7;
    ce_cnt       = 0;
    reset_active = 1'b0;
    exp_clear    = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_state", {29'd0, bus.state_o}, 32'd7);
    chk("rst_sync", {31'd0, bus.SYNC_o}, 32'd0);
    chk("rst_onehot", {24'd0, bus.state_oh_o}, 32'h80);
    chk("rst_phi1_rise", {31'd0, bus.phi1_rise_o}, 32'd0);
    chk("rst_phi2_rise", {31'd0, bus.phi2_rise_o}, 32'd0);
    chk("rst_cycle_end", {31'd0, bus.cycle_end_o}, 32'd0);
    chk("rst_cpu_clear", {31'd0, bus.cpu_clear_o}, 32'd0);
    chk("rst_phase_err", {31'd0, bus.phase_err_o}, 32'd0);
  endtask

  initial begin
    bus.PHI1_i  = 1'b0;
    bus.PHI2_i  = 1'b0;
    bus.RESET_i = 1'b0;
    do_reset();
    chk_reset_values();
    steps(3);

    // Latency: PHI2 driven just after edge n, pulse and state change at n+3.
    bus.PHI2_i = 1'b1;
    push_rise();
    step();
    chk("lat_n1", {31'd0, bus.phi2_rise_o}, 32'd0);
    step();
    chk("lat_n2", {31'd0, bus.phi2_rise_o}, 32'd0);
    step();
    chk("lat_n3", {31'd0, bus.phi2_rise_o}, 32'd1);
    chk("lat_state", {29'd0, bus.state_o}, 32'd0);
    step();
    chk("lat_n4", {31'd0, bus.phi2_rise_o}, 32'd0);
    bus.PHI2_i = 1'b0;
    steps(2);

    // Remaining states 1..7, then the wrap to 0 with cycle_end.
    for (int i = 0; i < 8; i++) phi_cycle();
    chk("wrap_state", {29'd0, bus.state_o}, 32'd0);

    // RESET held for 7 machine cycles: no clear, counter returns to 0.
    bus.RESET_i  = 1'b1;
    reset_active = 1'b1;
    for (int i = 0; i < 7 * 8; i++) phi_cycle();
    chk("clear_after7", {31'd0, bus.cpu_clear_o}, 32'd0);
    bus.RESET_i = 1'b0;
    steps(2);
    reset_active = 1'b0;
    ce_cnt       = 0;
    exp_clear    = 1'b0;
    step();

    // RESET held 9 machine cycles: clear rises with the 8th wrap and holds.
    bus.RESET_i  = 1'b1;
    reset_active = 1'b1;
    for (int i = 0; i < 9 * 8; i++) phi_cycle();
    chk("clear_held", {31'd0, bus.cpu_clear_o}, 32'd1);
    bus.RESET_i = 1'b0;
    steps(2);
    chk("clear_before_drop", {31'd0, bus.cpu_clear_o}, 32'd1);
    reset_active = 1'b0;
    ce_cnt       = 0;
    exp_clear    = 1'b0;
    step();
    chk("clear_dropped", {31'd0, bus.cpu_clear_o}, 32'd0);

    chk("phi1_count", phi1_seen, phi1_exp);
    chk("phase_err_clean", {31'd0, bus.phase_err_o}, 32'd0);

    // PHI1 and PHI2 rising together: both pulses, state still advances.
    bus.PHI1_i = 1'b1;
    bus.PHI2_i = 1'b1;
    push_rise();
    steps(3);
    chk("both_phi1", {31'd0, bus.phi1_rise_o}, 32'd1);
    chk("both_phi2", {31'd0, bus.phi2_rise_o}, 32'd1);
    step();
    bus.PHI1_i = 1'b0;
    bus.PHI2_i = 1'b0;
    steps(3);
    chk("phase_err_both", {31'd0, bus.phase_err_o}, {31'd0, EXP_ERR});
    phi_cycle();
    chk("phase_err_both_sticky", {31'd0, bus.phase_err_o}, {31'd0, EXP_ERR});

    // PHI2 high across rst release: no edge until it goes low then high.
    bus.PHI2_i = 1'b1;
    do_reset();
    chk_reset_values();
    steps(6);
    chk("no_rise_after_rst", {29'd0, bus.state_o}, 32'd7);
    bus.PHI2_i = 1'b0;
    steps(3);
    bus.PHI2_i = 1'b1;
    push_rise();
    steps(5);
    bus.PHI2_i = 1'b0;
    steps(3);
    chk("phase_err_first_phi2", {31'd0, bus.phase_err_o}, 32'd0);
    bus.PHI2_i = 1'b1;
    push_rise();
    steps(5);
    bus.PHI2_i = 1'b0;
    steps(3);
    chk("phase_err_double_phi2", {31'd0, bus.phase_err_o}, {31'd0, EXP_ERR});
    phi_cycle();
    phi_cycle();
    chk("phase_err_double_sticky", {31'd0, bus.phase_err_o}, {31'd0, EXP_ERR});

    do_reset();
    chk_reset_values();
    steps(2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i4004_timing.md
I4004_TIMING -- requirements
Module: i4004_timing

Interface
REQ-001 The block SHALL take parameter SYNC_STAGES, default 2, meaning the synchronizer flop depth per asynchronous input; legal range 1..4.
REQ-002 The block SHALL take parameter RESET_CYCLES, default 8, meaning the number of complete machine cycles RESET_I must be held before clear; legal range 1..255.
REQ-003 The block SHALL take parameter SYNC_STATE, default 7, meaning the state index (0..7) during which SYNC_o is driven low.
REQ-004 clk_i  input  1  main design clock (not a CPU pin); it is the only clock, and all logic is on its rising edge.
REQ-005 rst_i  input  1  block reset; synchronous, active-high.
REQ-006 PHI1_i  input  1  CPU clock phase 1; asynchronous to clk_i.
REQ-007 PHI2_i  input  1  CPU clock phase 2; asynchronous to clk_i.
REQ-008 RESET_i  input  1  CPU reset pin, active-high; asynchronous to clk_i; distinct from rst_i.
REQ-009 SYNC_o  output  1  machine-cycle sync; low only while state_o equals SYNC_STATE.
REQ-010 state_o  output  3  current state: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-011 state_oh_o  output  8  one-hot copy of state_o; bit n is high when state_o equals n.
REQ-012 phi1_rise_o  output  1  one-clk pulse on a synchronized PHI1 rising edge.
REQ-013 phi2_rise_o  output  1  one-clk pulse on a synchronized PHI2 rising edge.
REQ-014 cycle_end_o  output  1  one-clk pulse when state advances from X3 to A1.
REQ-015 cpu_clear_o  output  1  CPU internal-clear request.
REQ-016 phase_err_o  output  1  sticky phase-error flag.

Function
REQ-017 PHI1_i, PHI2_i and RESET_i SHALL each pass through an SYNC_STAGES-deep flop chain before any use.
REQ-018 A rise pulse SHALL be registered, asserted for exactly one clk when the synchronized value is 1 and its previous-cycle copy is 0, giving a latency of SYNC_STAGES+1 clk edges from the first edge that samples the input high.
REQ-019 state_o SHALL advance by one modulo 8 (X3 wraps to A1) on the same clk edge that asserts phi2_rise_o; PHI1 SHALL NOT change state.
REQ-020 SYNC_o and state_oh_o SHALL be registered consistently with state_o, with no cycle of skew.
REQ-021 cycle_end_o SHALL assert on the same clk edge that state_o changes from 7 to 0.
REQ-022 While synchronized RESET is high, a saturating counter SHALL count cycle_end_o pulses.
REQ-023 cpu_clear_o SHALL assert on the edge at which the counter reaches RESET_CYCLES, and SHALL hold while synchronized RESET stays high.
REQ-024 When synchronized RESET goes low, the counter and cpu_clear_o SHALL clear on the next clk edge.
REQ-025 The state sequence SHALL keep running while RESET is high; RESET SHALL NOT reposition state.
REQ-026 If PHI1 and PHI2 rise in the same clk, both pulses SHALL be emitted and state SHALL advance normally.

Reset
REQ-027 On rst_i, state_o SHALL reset to 7 (X3), SYNC_o to 0, state_oh_o to 8'h80, and all pulse outputs, cpu_clear_o, phase_err_o and the reset counter to 0.
REQ-028 On rst_i, all PHI synchronizer stages and their previous-value copies SHALL reset to 1, so no edge is reported until a phase is first seen low and then high.
REQ-029 On rst_i, the RESET_i synchronizer stages SHALL reset to 0.
REQ-030 When rst_i is asserted mid-cycle it SHALL override every other event in that clk.

Configuration
REQ-031 With I4004_TIMING_PHASE_CHECK_EN defined, phase_err_o SHALL set and hold until rst_i when either:
- synchronized PHI1 and PHI2 are high in the same clk; or
- two phi2_rise_o pulses occur without an intervening phi1_rise_o, with the first phi2 after reset exempt.
REQ-032 Without I4004_TIMING_PHASE_CHECK_EN, phase_err_o SHALL be tied to 0 and the checker logic SHALL be absent.

Verification
REQ-033 Defaults, clean alternating PHI1/PHI2 for 8 PHI2 rises after reset -> state_o goes 0,1,...,7; SYNC_o is low only in state 7; cycle_end_o pulses once at 7->0.
REQ-034 PHI2_i goes high at clk edge n, SYNC_STAGES=2 -> phi2_rise_o high only at edge n+3, and state_o increments at edge n+3.
REQ-035 RESET_i held for 8 machine cycles with RESET_CYCLES=8 -> cpu_clear_o rises with the 8th cycle_end_o; dropping RESET_i clears it one clk after the synchronized low.
REQ-036 RESET_i held for 7 machine cycles and then released -> cpu_clear_o never asserts, and the counter returns to 0.
REQ-037 PHI2 high at release of rst_i -> no phi2_rise_o until PHI2 has gone low and then high again.
REQ-038 With I4004_TIMING_PHASE_CHECK_EN defined, PHI1 and PHI2 forced high together for 1 clk, or two PHI2 pulses with no PHI1 between -> phase_err_o = 1 and stays 1 until rst_i; without the macro, phase_err_o = 0.
